// File: rtl/uart_flow_ctrl_core.sv
// Full-duplex UART with RTS/CTS flow control, optional parity and a first-word
// fall-through RX FIFO. Serial inputs are double-flopped before use.
module uart_flow_ctrl_core #(
    parameter int unsigned CLOCK_SPEED = 100000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_ENA  = 0,
    parameter int unsigned PARITY_TYPE = 0,
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned RTS_MARGIN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 rx_overflow,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    output logic                 uart_rtsn,
    input  logic                 uart_ctsn
);

    localparam int unsigned DIV   = CLOCK_SPEED / BAUD_RATE;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = 4;
    localparam int unsigned AW    = $clog2(RX_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam bit          PAR_ENA = (PARITY_ENA != 0);
    localparam bit          PAR_ODD = (PARITY_TYPE != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    typedef struct packed {
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } rx_entry_t;

    // ---------------- input synchronisers ----------------
    logic r_rxd_s1, r_rxd_s2, r_rxd_prev, r_ctsn_s1, r_ctsn_s2;

    // Two-flop synchronisers plus a delayed copy of rxd for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_ctsn_s1  <= 1'b1;
            r_ctsn_s2  <= 1'b1;
        end else begin
            r_rxd_s1   <= uart_rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
            r_ctsn_s1  <= uart_ctsn;
            r_ctsn_s2  <= r_ctsn_s1;
        end
    end

    // ---------------- transmitter ----------------
    state_t               r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nxt;
    logic [BIT_W-1:0]     r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_data, w_tx_shift;
    logic                 r_txd, w_txd_nxt, w_tx_tick, w_tx_accept;

    assign s_ready     = (r_tx_state == S_IDLE) & ~r_ctsn_s2;
    assign w_tx_accept = s_ready & s_valid;
    assign w_tx_tick   = (r_tx_cnt == CNT_W'(DIV - 1));
    assign w_tx_shift  = r_tx_data >> w_tx_bit_nxt;
    assign uart_txd    = r_txd;

    // TX next state, bit timer and bit index
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_bit_nxt = '0;
                if (w_tx_accept) w_tx_state_nxt = S_START;
            end
            S_START: if (w_tx_tick) begin
                w_tx_cnt_nxt   = '0;
                w_tx_state_nxt = S_DATA;
            end
            S_DATA: if (w_tx_tick) begin
                w_tx_cnt_nxt = '0;
                if (r_tx_bit == BIT_W'(DATA_BITS - 1)) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = PAR_ENA ? S_PARITY : S_STOP;
                end else begin
                    w_tx_bit_nxt = r_tx_bit + 1'b1;
                end
            end
            S_PARITY: if (w_tx_tick) begin
                w_tx_cnt_nxt   = '0;
                w_tx_state_nxt = S_STOP;
            end
            S_STOP: if (w_tx_tick) begin
                w_tx_cnt_nxt = '0;
                if (r_tx_bit == BIT_W'(STOP_BITS - 1)) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = S_IDLE;
                end else begin
                    w_tx_bit_nxt = r_tx_bit + 1'b1;
                end
            end
            default: begin
                w_tx_cnt_nxt   = '0;
                w_tx_bit_nxt   = '0;
                w_tx_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so txd is a clean register
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_tx_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_tx_shift[0];
            S_PARITY: w_txd_nxt = (^r_tx_data) ^ PAR_ODD;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    // TX state register, timers, word latch and line register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_data  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_txd      <= w_txd_nxt;
            if (w_tx_accept) r_tx_data <= s_data;
        end
    end

    // ---------------- receiver ----------------
    state_t               r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_nxt;
    logic [BIT_W-1:0]     r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par, w_rx_tick, w_rx_half, w_rx_fall, w_rx_push;
    rx_entry_t            w_rx_entry;

    assign w_rx_fall = r_rxd_prev & ~r_rxd_s2;
    assign w_rx_half = (r_rx_cnt == CNT_W'(HALF - 1));
    assign w_rx_tick = (r_rx_cnt == CNT_W'(DIV - 1));

    assign w_rx_entry.ferr = ~r_rxd_s2;
    assign w_rx_entry.perr = PAR_ENA & ((^r_rx_shift) ^ r_rx_par ^ PAR_ODD);
    assign w_rx_entry.data = r_rx_shift;

    // RX next state: start validated at mid-bit, then one sample per bit period
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_push      = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                w_rx_bit_nxt = '0;
                if (w_rx_fall) w_rx_state_nxt = S_START;
            end
            S_START: if (w_rx_half) begin
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = r_rxd_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_tick) begin
                w_rx_cnt_nxt = '0;
                if (r_rx_bit == BIT_W'(DATA_BITS - 1)) begin
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = PAR_ENA ? S_PARITY : S_STOP;
                end else begin
                    w_rx_bit_nxt = r_rx_bit + 1'b1;
                end
            end
            S_PARITY: if (w_rx_tick) begin
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = S_STOP;
            end
            S_STOP: if (w_rx_tick) begin
                w_rx_cnt_nxt   = '0;
                w_rx_push      = 1'b1;
                w_rx_state_nxt = S_IDLE;
            end
            default: begin
                w_rx_cnt_nxt   = '0;
                w_rx_bit_nxt   = '0;
                w_rx_state_nxt = S_IDLE;
            end
        endcase
    end

    // RX state register, sampling timers and LSB-first shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            if (r_rx_state == S_DATA && w_rx_tick)
                r_rx_shift <= {r_rxd_s2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_state == S_PARITY && w_rx_tick)
                r_rx_par <= r_rxd_s2;
        end
    end

    // ---------------- RX FIFO and RTS ----------------
    rx_entry_t     r_mem [RX_DEPTH];
    rx_entry_t     w_head;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf, r_rtsn, w_full, w_pop, w_push_ok;

    assign w_full    = (r_count == CW'(RX_DEPTH));
    assign m_valid   = (r_count != '0);
    assign w_pop     = m_valid & m_ready;
    assign w_push_ok = w_rx_push & (~w_full | w_pop);
    assign w_head    = r_mem[r_rd_ptr];

    assign m_data      = m_valid ? w_head.data : '0;
    assign m_perr      = m_valid & w_head.perr;
    assign m_ferr      = m_valid & w_head.ferr;
    assign rx_overflow = r_ovf;
    assign uart_rtsn   = r_rtsn;

    // Storage array; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_rx_entry;
    end

    // Pointers, occupancy, overflow pulse and RTS threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_rtsn   <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            r_ovf  <= w_rx_push & w_full & ~w_pop;
            r_rtsn <= (r_count >= CW'(RX_DEPTH - RTS_MARGIN));
        end
    end

endmodule
